// File: rtl/l2_line_merge_buffer_if.sv
// Bundles the load, write-beat and merged-line handshakes plus merge status.
// The master modport drives the buffer; the slave modport is the buffer itself.
interface l2_line_merge_buffer_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 128,
  parameter int CNT_WIDTH  = 8
);
  localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFS_WIDTH = $clog2(BEATS);

  logic                      load_valid;
  logic                      load_ready;
  logic [LINE_WIDTH-1:0]     load_line;

  logic                      wr_valid;
  logic                      wr_ready;
  logic [OFS_WIDTH-1:0]      wr_offset;
  logic [BEAT_WIDTH-1:0]     wr_data;
  logic [BEAT_WIDTH/8-1:0]   wr_byte_en;
  logic                      wr_last;

  logic                      out_valid;
  logic                      out_ready;
  logic [LINE_WIDTH-1:0]     out_line;
  logic [LINE_WIDTH/8-1:0]   out_byte_dirty;

  logic [CNT_WIDTH-1:0]      wr_count;
  logic                      busy;

  modport master (
    output load_valid, load_line,
    output wr_valid, wr_offset, wr_data, wr_byte_en, wr_last,
    output out_ready,
    input  load_ready, wr_ready, out_valid, out_line, out_byte_dirty, wr_count, busy
  );

  modport slave (
    input  load_valid, load_line,
    input  wr_valid, wr_offset, wr_data, wr_byte_en, wr_last,
    input  out_ready,
    output load_ready, wr_ready, out_valid, out_line, out_byte_dirty, wr_count, busy
  );
endinterface

// File: rtl/l2_line_merge_buffer.sv
// L2 write-merge buffer: captures a base line, merges byte-masked beats into it,
// then offers the merged line and its per-byte dirty mask to the L2 array.
module l2_line_merge_buffer #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 128,
  parameter int CNT_WIDTH  = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  l2_line_merge_buffer_if.slave bus
);
  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int OFS_WIDTH  = $clog2(BEATS);
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;
  localparam int LINE_BYTES = LINE_WIDTH / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MERGE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_reg;
  logic [LINE_WIDTH-1:0] line_reg;
  logic [LINE_BYTES-1:0] dirty_reg;
  logic [CNT_WIDTH-1:0]  wr_count_reg;

  logic [LINE_WIDTH-1:0] line_next;
  logic [LINE_BYTES-1:0] dirty_next;

  // Each line byte belongs to one beat slot and one lane within that beat;
  // it is replaced only when the beat targets its slot and its lane is enabled.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_byte
      localparam logic [OFS_WIDTH-1:0] SLOT = OFS_WIDTH'(gi / BEAT_BYTES);
      localparam int                   LANE = gi % BEAT_BYTES;
      logic byte_hit;

      assign byte_hit            = (bus.wr_offset == SLOT) && bus.wr_byte_en[LANE];
      assign line_next[gi*8 +: 8] = byte_hit ? bus.wr_data[LANE*8 +: 8] : line_reg[gi*8 +: 8];
      assign dirty_next[gi]      = dirty_reg[gi] | byte_hit;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      line_reg     <= '0;
      dirty_reg    <= '0;
      wr_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.load_valid) begin
            line_reg     <= bus.load_line;
            dirty_reg    <= '0;
            wr_count_reg <= '0;
            state_reg    <= MERGE;
          end
        end
        MERGE: begin
          if (bus.wr_valid) begin
            line_reg  <= line_next;
            dirty_reg <= dirty_next;
            if (wr_count_reg != {CNT_WIDTH{1'b1}})
              wr_count_reg <= wr_count_reg + CNT_WIDTH'(1);
            if (bus.wr_last)
              state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Merged state is left in place after the hand-off until the next load.
          if (bus.out_ready)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.load_ready     = (state_reg == IDLE);
  assign bus.wr_ready       = (state_reg == MERGE);
  assign bus.out_valid      = (state_reg == DRAIN);
  assign bus.busy           = (state_reg != IDLE);
  assign bus.out_line       = line_reg;
  assign bus.out_byte_dirty = dirty_reg;
  assign bus.wr_count       = wr_count_reg;
endmodule

// File: doc/l2_line_merge_buffer.md
Name: l2_line_merge_buffer

Overview:
Parametrised write-merge buffer for the L2 data path. It captures the current L2 line and merges any number of byte-masked sub-line writes from L1 into it over several cycles. It then presents the merged line, with a per-byte dirty mask, to the L2 array write port over a valid/ready handshake. It sits between the L2 controller datapath and the L2 data array.

Parameters:
LINE_WIDTH, 256, bits per L2 line; must be a multiple of BEAT_WIDTH.
BEAT_WIDTH, 128, bits per write beat; must be a multiple of 8.
BEATS, LINE_WIDTH/BEAT_WIDTH (derived), beats per line; must be a power of 2 and at least 2.
OFS_WIDTH, clog2(BEATS) (derived), offset width.
CNT_WIDTH, 8, width of the accepted-beat counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
load_valid  in  1  load_line is valid.
load_ready  out  1  buffer accepts a new base line.
load_line  in  LINE_WIDTH  current L2 line contents.
wr_valid  in  1  write beat is valid.
wr_ready  out  1  buffer accepts a write beat.
wr_offset  in  OFS_WIDTH  beat index within the line.
wr_data  in  BEAT_WIDTH  write data.
wr_byte_en  in  BEAT_WIDTH/8  per-byte write enable.
wr_last  in  1  this beat closes the merge.
out_valid  out  1  merged line is available.
out_ready  in  1  L2 array accepts the line.
out_line  out  LINE_WIDTH  merged line.
out_byte_dirty  out  LINE_WIDTH/8  bytes written during this merge.
wr_count  out  CNT_WIDTH  beats accepted in the current merge.
busy  out  1  state is not IDLE.

Behaviour:
- Handshake rule: a transfer occurs on a rising edge where valid and ready are both 1. Ready signals never depend combinationally on the corresponding valid.
- FSM states: IDLE, MERGE, DRAIN.
- Output decode: load_ready = (IDLE); wr_ready = (MERGE); out_valid = (DRAIN); busy = not IDLE.
- IDLE:
  - On a load transfer: line_reg <= load_line, dirty <= 0, wr_count <= 0, go to MERGE.
  - wr_valid is ignored.
- MERGE, on a write transfer:
  - For each byte i with wr_byte_en[i]=1: line byte (wr_offset*BEAT_WIDTH/8 + i) <= wr_data byte i, and the matching dirty bit is set.
  - Bytes with enable 0 are unchanged. Dirty bits only ever OR in.
  - wr_count increments and saturates at 2^CNT_WIDTH-1.
  - A beat with all enables 0 is legal: the line is unchanged but the beat is counted.
  - Repeated offsets are legal: the later write wins per byte.
  - If wr_last=1 on the transfer, go to DRAIN after applying the beat.
- DRAIN:
  - out_line = line_reg and out_byte_dirty = dirty, both driven directly from registers.
  - Both are held stable while out_valid=1 and out_ready=0.
  - On an out transfer, go to IDLE. line_reg, dirty and wr_count keep their values until the next load.
- Latency:
  - load transfer to wr_ready=1: 1 cycle.
  - wr_last transfer to out_valid=1: 1 cycle.
  - out transfer to load_ready=1: 1 cycle.
  - Minimum cycle count for a one-beat merge: 3 (load, write, drain).
- No bypass paths:
  - A load is never accepted in the same cycle as an out transfer.
  - A write is never accepted in the same cycle as a load.
- Reset, asserted asynchronously at any time, including mid-MERGE or mid-DRAIN:
  - state=IDLE, line_reg=0, dirty=0, wr_count=0.
  - Hence load_ready=1, wr_ready=0, out_valid=0, busy=0, out_line=0, out_byte_dirty=0, wr_count=0.
  - Any in-progress merge is discarded; no partial out transfer is produced.
- Width rules: the byte lane base is wr_offset*(BEAT_WIDTH/8), which never exceeds the line because BEATS is a power of 2.

Test Plan:
- Basic merge (defaults):
  - Stimulus: load 256'hAA..AA; write offset=1, data 128'h11..11, en=16'hFFFF, last=1.
  - Required: out_line[255:128]=11..11, out_line[127:0]=AA..AA, out_byte_dirty=32'hFFFF0000, wr_count=1, out_valid exactly 1 cycle after the wr_last transfer.
- Partial bytes and overwrite:
  - Stimulus: load 0; write offset 0, en=16'h000F, data 32'hDEADBEEF in the low bytes; then write offset 0, en=16'h0001, data byte 8'h55, last=1.
  - Required: out_line[31:0]=32'hDEADBE55, out_byte_dirty=32'h0000000F, wr_count=2.
- Zero-enable beat:
  - Stimulus: load 256'h5A..5A; write offset 1, en=0, last=1.
  - Required: out_line=256'h5A..5A, out_byte_dirty=0, wr_count=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DRAIN while load_valid=1.
  - Required: out_line/out_byte_dirty stable, load_ready=0, wr_ready=0 throughout; after out_ready=1, load accepted no earlier than the next cycle.
- Async reset mid-MERGE:
  - Stimulus: after 2 beats, pulse reset_n low between clock edges.
  - Required: immediately busy=0, wr_ready=0, load_ready=1, wr_count=0, out_byte_dirty=0; the next load starts a clean merge.
- Parameter sweep:
  - Stimulus: LINE_WIDTH=512, BEAT_WIDTH=64 (BEATS=8); write offset 7, en=8'h80, data byte 7=8'hC3.
  - Required: out_line[511:504]=8'hC3, only out_byte_dirty[63]=1.
